// File: rtl/mmu_req_arbiter.sv
// mmu_req_arbiter_pkg: address widths, exception record and cause codes
// shared by the arbiter and its users.
//
// mmu_req_arbiter: round-robin arbiter sharing one load/store MMU translation
// port between NumReq requesters. One translation runs at a time. The MMU
// response goes back to the granted requester. A watchdog aborts translations
// that never answer. A flush drops the pending translation. When translation
// is disabled, the MMU is bypassed with an identity mapping.
//
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   en_ld_st_translation_i         translation enable, sampled at grant
//   flush_i                        abort pending translation, no response
//   req_i / vaddr_i / is_store_i   per-requester request, address, store flag
//   gnt_o                          one-hot single-cycle grant
//   resp_valid_o                   one-hot response strobe
//   resp_paddr_o/resp_exception_o  shared response payload ('0 when idle)
//   busy_o                         a translation or bypass is in flight
//   mmu_*_o / mmu_*_i              MMU request and result side
package mmu_req_arbiter_pkg;
  localparam int unsigned XLEN = 64;
  localparam int unsigned VLEN = 39;
  localparam int unsigned PLEN = 56;

  localparam logic [XLEN-1:0] LD_ACCESS_FAULT  = 64'd5;
  localparam logic [XLEN-1:0] ST_ACCESS_FAULT  = 64'd7;
  localparam logic [XLEN-1:0] LOAD_PAGE_FAULT  = 64'd13;
  localparam logic [XLEN-1:0] STORE_PAGE_FAULT = 64'd15;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;
endpackage

module mmu_req_arbiter
  import mmu_req_arbiter_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_ld_st_translation_i,
  input  logic                         flush_i,
  input  logic [NumReq-1:0]            req_i,
  input  logic [NumReq-1:0][VLEN-1:0]  vaddr_i,
  input  logic [NumReq-1:0]            is_store_i,
  output logic [NumReq-1:0]            gnt_o,
  output logic [NumReq-1:0]            resp_valid_o,
  output logic [PLEN-1:0]              resp_paddr_o,
  output exception_t                   resp_exception_o,
  output logic                         busy_o,
  output logic                         mmu_en_ld_st_translation_o,
  output logic                         mmu_req_o,
  output logic [VLEN-1:0]              mmu_vaddr_o,
  output logic                         mmu_is_store_o,
  input  logic                         mmu_valid_i,
  input  logic [PLEN-1:0]              mmu_paddr_i,
  input  exception_t                   mmu_exception_i
);
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(TimeoutCycles);

  typedef enum logic [1:0] {IDLE, WAIT, BYPASS, DRAIN} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic [IdxW-1:0] rr_q;
  logic [VLEN-1:0] vaddr_q;
  logic            is_store_q;
  logic [CntW-1:0] cnt_q;

  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] rr_next;
  int unsigned     cand;
  logic            grant;
  logic            timeout;
  logic            resp_fire;

  function automatic exception_t access_fault(input logic             is_store,
                                              input logic [VLEN-1:0]  vaddr);
    exception_t ex;
    ex.cause = is_store ? ST_ACCESS_FAULT : LD_ACCESS_FAULT;
    ex.tval  = XLEN'(vaddr);
    ex.valid = 1'b1;
    return ex;
  endfunction

  // Winner is the first requester found scanning upward from rr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = (32'(rr_q) + i) % NumReq;
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  assign rr_next = (32'(win_idx) == NumReq - 1) ? '0 : win_idx + IdxW'(1);
  // Gated with reset so no grant is seen while the arbiter is held in reset.
  assign grant   = (state_q == IDLE) && win_found && !flush_i && rst_ni;
  assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));

  assign gnt_o                      = grant ? (NumReq'(1) << win_idx) : '0;
  assign busy_o                     = (state_q != IDLE);
  assign mmu_en_ld_st_translation_o = en_ld_st_translation_i;
  assign mmu_req_o                  = grant && en_ld_st_translation_i;
  assign mmu_vaddr_o                = mmu_req_o ? vaddr_i[win_idx] : '0;
  assign mmu_is_store_o             = mmu_req_o ? is_store_i[win_idx] : 1'b0;

  // A real MMU result beats a watchdog expiry in the same cycle; a flush in
  // either case swallows the response.
  always_comb begin
    resp_fire        = 1'b0;
    resp_paddr_o     = '0;
    resp_exception_o = '0;
    case (state_q)
      WAIT: begin
        if (!flush_i) begin
          if (mmu_valid_i) begin
            resp_fire        = 1'b1;
            resp_paddr_o     = mmu_paddr_i;
            resp_exception_o = mmu_exception_i;
          end else if (timeout) begin
            resp_fire        = 1'b1;
            resp_exception_o = access_fault(is_store_q, vaddr_q);
          end
        end
      end
      BYPASS: begin
        if (!flush_i) begin
          resp_fire    = 1'b1;
          resp_paddr_o = PLEN'(vaddr_q);
        end
      end
      default: ;
    endcase
  end

  assign resp_valid_o = resp_fire ? (NumReq'(1) << idx_q) : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rr_q       <= '0;
      vaddr_q    <= '0;
      is_store_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            idx_q      <= win_idx;
            vaddr_q    <= vaddr_i[win_idx];
            is_store_q <= is_store_i[win_idx];
            rr_q       <= rr_next;
            cnt_q      <= '0;
            state_q    <= en_ld_st_translation_i ? WAIT : BYPASS;
          end
        end
        WAIT: begin
          if (mmu_valid_i || timeout) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (flush_i) state_q <= DRAIN;
          end
        end
        BYPASS: state_q <= IDLE;
        DRAIN: begin
          if (mmu_valid_i || timeout) state_q <= IDLE;
          else                        cnt_q   <= cnt_q + CntW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmu_req_arbiter.sv
// Testbench for mmu_req_arbiter: directed scenarios followed by randomized
// transactions checked against a transaction-level reference model.
module tb_mmu_req_arbiter;
  import mmu_req_arbiter_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned TC = 4;

  logic                    clk = 1'b0;
  logic                    rst_ni;
  logic                    en;
  logic                    flush;
  logic [NR-1:0]           req;
  logic [NR-1:0][VLEN-1:0] vaddr;
  logic [NR-1:0]           is_store;
  logic [NR-1:0]           gnt;
  logic [NR-1:0]           resp_valid;
  logic [PLEN-1:0]         resp_paddr;
  exception_t              resp_exc;
  logic                    busy;
  logic                    mmu_en;
  logic                    mmu_req;
  logic [VLEN-1:0]         mmu_vaddr;
  logic                    mmu_is_store;
  logic                    mmu_valid;
  logic [PLEN-1:0]         mmu_paddr;
  exception_t              mmu_exc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mmu_req_arbiter #(.NumReq(NR), .TimeoutCycles(TC)) dut (
    .clk_i                      (clk),
    .rst_ni                     (rst_ni),
    .en_ld_st_translation_i     (en),
    .flush_i                    (flush),
    .req_i                      (req),
    .vaddr_i                    (vaddr),
    .is_store_i                 (is_store),
    .gnt_o                      (gnt),
    .resp_valid_o               (resp_valid),
    .resp_paddr_o               (resp_paddr),
    .resp_exception_o           (resp_exc),
    .busy_o                     (busy),
    .mmu_en_ld_st_translation_o (mmu_en),
    .mmu_req_o                  (mmu_req),
    .mmu_vaddr_o                (mmu_vaddr),
    .mmu_is_store_o             (mmu_is_store),
    .mmu_valid_i                (mmu_valid),
    .mmu_paddr_i                (mmu_paddr),
    .mmu_exception_i            (mmu_exc)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    req       = '0;
    flush     = 1'b0;
    mmu_valid = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  // Reference model state
  int unsigned      exp_rr;
  logic [NR-1:0]    pend;
  logic [VLEN-1:0]  va [NR];
  logic [NR-1:0]    st;
  int               w;
  int unsigned      c_idx;
  int unsigned      lat;
  int unsigned      rc;
  logic             e;
  logic [PLEN-1:0]  pa;
  exception_t       ex;
  logic [PLEN-1:0]  exp_pa;
  exception_t       exp_ex;
  int               cnt0;
  int               cnt1;

  initial begin
    en       = 1'b1;
    vaddr    = '0;
    is_store = '0;
    mmu_paddr = '0;
    mmu_exc  = '0;
    do_reset();
    rst_ni = 1'b0;
    settle();
    check("rst_gnt", gnt, '0);
    check("rst_resp_valid", resp_valid, '0);
    check("rst_resp_paddr", resp_paddr, '0);
    check("rst_resp_exc", resp_exc, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_mmu_req", mmu_req, 1'b0);
    check("rst_mmu_en", mmu_en, 1'b1);
    rst_ni = 1'b1;

    // Single translated request
    req = 2'b01; vaddr[0] = 39'h1000; is_store = 2'b00; en = 1'b1;
    settle();
    check("single_gnt", gnt, 2'b01);
    check("single_mmu_req", mmu_req, 1'b1);
    check("single_mmu_vaddr", mmu_vaddr, 39'h1000);
    check("single_busy_T", busy, 1'b0);
    tick();
    req = '0; mmu_valid = 1'b1; mmu_paddr = 56'h1000; mmu_exc = '0;
    settle();
    check("single_resp_valid", resp_valid, 2'b01);
    check("single_resp_paddr", resp_paddr, 56'h1000);
    check("single_busy_T1", busy, 1'b1);
    tick();
    mmu_valid = 1'b0;
    settle();
    check("single_idle_T2", busy, 1'b0);
    check("single_resp_T2", resp_valid, '0);

    // Fairness from reset
    do_reset();
    req = 2'b11; vaddr[0] = 39'h100; vaddr[1] = 39'h200; en = 1'b1;
    exp_rr = 0; cnt0 = 0; cnt1 = 0;
    for (int g = 0; g < 8; g++) begin
      settle();
      check("fair_gnt", gnt, NR'(1) << exp_rr);
      if (gnt == 2'b01) cnt0++;
      if (gnt == 2'b10) cnt1++;
      tick();
      mmu_valid = 1'b1;
      mmu_paddr = (exp_rr == 0) ? 56'h100 : 56'h200;
      settle();
      check("fair_resp", resp_valid, NR'(1) << exp_rr);
      check("fair_no_gnt_busy", gnt, '0);
      tick();
      mmu_valid = 1'b0;
      exp_rr = (exp_rr + 1) % NR;
    end
    check("fair_count0", cnt0, 4);
    check("fair_count1", cnt1, 4);

    // Bypass with translation disabled
    req = 2'b10; vaddr[1] = 39'h7F_FFFF_F000; en = 1'b0;
    settle();
    check("bypass_gnt", gnt, 2'b10);
    check("bypass_no_mmu_req", mmu_req, 1'b0);
    tick();
    req = '0;
    settle();
    check("bypass_resp_valid", resp_valid, 2'b10);
    check("bypass_paddr", resp_paddr, 56'h7F_FFFF_F000);
    check("bypass_exc", resp_exc, '0);
    tick();
    settle();
    check("bypass_idle", busy, 1'b0);

    // Exception pass-through on a store
    en = 1'b1; req = 2'b01; vaddr[0] = 39'h23_4567_8000; is_store = 2'b01;
    settle();
    check("exc_gnt", gnt, 2'b01);
    check("exc_mmu_is_store", mmu_is_store, 1'b1);
    tick();
    req = '0; mmu_valid = 1'b1; mmu_paddr = '0;
    mmu_exc = exception_t'{cause: STORE_PAGE_FAULT, tval: 64'h23_4567_8000, valid: 1'b1};
    settle();
    check("exc_resp_valid", resp_valid, 2'b01);
    check("exc_resp_exc", resp_exc,
          exception_t'{cause: 64'd15, tval: 64'h23_4567_8000, valid: 1'b1});
    tick();
    mmu_valid = 1'b0; mmu_exc = '0; is_store = '0;

    // Watchdog timeout on a load
    req = 2'b10; vaddr[1] = 39'h4000;
    settle();
    check("to_gnt", gnt, 2'b10);
    for (int c = 1; c < 4; c++) begin
      tick();
      req = '0;
      settle();
      check("to_no_resp", resp_valid, '0);
      check("to_busy", busy, 1'b1);
    end
    tick();
    settle();
    check("to_resp_valid", resp_valid, 2'b10);
    check("to_resp_exc", resp_exc, exception_t'{cause: 64'd5, tval: 64'h4000, valid: 1'b1});
    check("to_resp_paddr", resp_paddr, '0);
    tick();
    settle();
    check("to_idle", busy, 1'b0);

    // Flush while waiting: drain the late result
    req = 2'b01; vaddr[0] = 39'h5000;
    settle();
    check("drain_gnt", gnt, 2'b01);
    tick();
    req = '0; flush = 1'b1;
    settle();
    check("drain_no_resp_T1", resp_valid, '0);
    tick();
    flush = 1'b0;
    settle();
    check("drain_busy_T2", busy, 1'b1);
    tick();
    mmu_valid = 1'b1; mmu_paddr = 56'h5000;
    settle();
    check("drain_no_resp_T3", resp_valid, '0);
    check("drain_paddr_T3", resp_paddr, '0);
    tick();
    mmu_valid = 1'b0;
    settle();
    check("drain_idle_T4", busy, 1'b0);

    // Flush in IDLE suppresses the grant
    req = 2'b01; flush = 1'b1;
    settle();
    check("idle_flush_gnt", gnt, '0);
    flush = 1'b0;
    settle();
    check("post_flush_gnt", gnt, 2'b01);
    // Flush coinciding with the MMU result
    tick();
    req = '0; flush = 1'b1; mmu_valid = 1'b1; mmu_paddr = 56'h6000;
    settle();
    check("flush_valid_resp", resp_valid, '0);
    check("flush_valid_paddr", resp_paddr, '0);
    tick();
    flush = 1'b0; mmu_valid = 1'b0;
    settle();
    check("flush_valid_idle", busy, 1'b0);

    // Reset in WAIT
    req = 2'b10; vaddr[1] = 39'h7000;
    settle();
    check("rstw_gnt", gnt, 2'b10);
    tick();
    req = '0; rst_ni = 1'b0;
    settle();
    tick();
    settle();
    check("rstw_outputs",
          {gnt, resp_valid, resp_paddr, resp_exc, busy, mmu_req, mmu_vaddr, mmu_is_store}, '0);
    rst_ni = 1'b1;
    exp_rr = 0;

    // Randomized transactions against the reference model
    pend = '0; st = '0;
    for (int r = 0; r < NR; r++) va[r] = '0;
    for (int t = 0; t < 200; t++) begin
      for (int r = 0; r < NR; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1'b1;
          va[r]   = VLEN'({$urandom, $urandom});
          st[r]   = 1'($urandom_range(0, 1));
        end
      end
      if (pend == '0) begin
        c_idx = $urandom_range(0, NR - 1);
        pend[c_idx] = 1'b1;
        va[c_idx]   = VLEN'({$urandom, $urandom});
        st[c_idx]   = 1'($urandom_range(0, 1));
      end
      req = pend;
      for (int r = 0; r < NR; r++) vaddr[r] = va[r];
      is_store = st;
      if ($urandom_range(0, 7) == 0) begin
        flush = 1'b1;
        settle();
        check("rnd_idle_flush_gnt", gnt, '0);
        tick();
        flush = 1'b0;
      end
      e  = 1'($urandom_range(0, 1));
      en = e;
      settle();
      w = -1;
      for (int k = 0; k < NR; k++) begin
        c_idx = (exp_rr + k) % NR;
        if (w < 0 && pend[c_idx]) w = int'(c_idx);
      end
      check("rnd_busy_idle", busy, 1'b0);
      check("rnd_gnt", gnt, NR'(1) << w);
      check("rnd_mmu_req", mmu_req, e);
      check("rnd_mmu_vaddr", mmu_vaddr, e ? va[w] : '0);
      check("rnd_mmu_is_store", mmu_is_store, e ? st[w] : 1'b0);
      pend[w] = 1'b0;
      exp_rr  = (w + 1) % NR;

      lat = $urandom_range(1, TC + 1);
      rc  = e ? ((lat <= TC) ? lat : TC) : 1;
      pa  = PLEN'({$urandom, $urandom});
      ex.cause = {$urandom, $urandom};
      ex.tval  = {$urandom, $urandom};
      ex.valid = 1'($urandom_range(0, 1));
      if (!e) begin
        exp_pa = PLEN'(va[w]);
        exp_ex = '0;
      end else if (lat <= TC) begin
        exp_pa = pa;
        exp_ex = ex;
      end else begin
        exp_pa = '0;
        exp_ex = exception_t'{cause: st[w] ? 64'd7 : 64'd5, tval: XLEN'(va[w]), valid: 1'b1};
      end

      for (int unsigned c = 1; c <= rc; c++) begin
        tick();
        req       = pend;
        mmu_valid = e && (c == lat);
        mmu_paddr = pa;
        mmu_exc   = ex;
        settle();
        check("rnd_no_gnt", gnt, '0);
        if (c == rc) begin
          check("rnd_resp_valid", resp_valid, NR'(1) << w);
          check("rnd_resp_paddr", resp_paddr, exp_pa);
          check("rnd_resp_exc", resp_exc, exp_ex);
        end else begin
          check("rnd_resp_quiet", {resp_valid, resp_paddr, resp_exc}, '0);
          check("rnd_busy", busy, 1'b1);
        end
      end
      tick();
      mmu_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
